// File: rtl/reg_file_32x32_pkg.sv
// Shared definitions for the register file and the datapath units it feeds.
// Holds the default operand width and depth, the register address type, and
// the state encoding of the array clear sequencer.
package reg_file_32x32_pkg;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 32;
    localparam int ADDR_W = $clog2(DEPTH);

    typedef logic [ADDR_W-1:0] reg_addr_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DONE  = 2'd2
    } clr_state_t;

endpackage

// File: rtl/reg_file_clear_ctrl.sv
// Clear sequencer for the register file. On clr_req it walks every entry
// index once, asserting clr_we, then spends one extra cycle in DONE before
// handing the write port back to the writeback path.
//
// Ports:
//   clk, rst   single clock, synchronous active-high reset
//   clr_req    one-cycle pulse that starts a clear (ignored unless idle)
//   clr_we     zero-write enable for entry clr_idx
//   clr_idx    entry being cleared this cycle
//   busy       clear in progress (registered)
//   wb_ready   writeback port open (registered)
//
// state | meaning
// IDLE  | waiting for clr_req, writeback port open
// CLEAR | zeroing entry clr_idx each cycle, last entry moves to DONE
// DONE  | final cycle of busy, reopens the writeback port
module reg_file_clear_ctrl
    import reg_file_32x32_pkg::*;
#(
    parameter int N_ENTRIES = 32,
    parameter int IDX_W     = $clog2(N_ENTRIES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_req,
    output logic             clr_we,
    output logic [IDX_W-1:0] clr_idx,
    output logic             busy,
    output logic             wb_ready
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ENTRIES - 1);

    clr_state_t       state, state_nxt;
    logic [IDX_W-1:0] idx_nxt;
    logic             busy_nxt;
    logic             ready_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            clr_idx  <= '0;
            busy     <= 1'b0;
            wb_ready <= 1'b0;
        end else begin
            state    <= state_nxt;
            clr_idx  <= idx_nxt;
            busy     <= busy_nxt;
            wb_ready <= ready_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = clr_idx;
        busy_nxt  = busy;
        ready_nxt = wb_ready;
        case (state)
            IDLE: begin
                // wb_ready first rises here on the edge after reset release.
                ready_nxt = 1'b1;
                if (clr_req) begin
                    state_nxt = CLEAR;
                    idx_nxt   = '0;
                    busy_nxt  = 1'b1;
                    ready_nxt = 1'b0;
                end
            end
            CLEAR: begin
                // The index stops on the last entry rather than wrapping.
                if (clr_idx == LAST_IDX) begin
                    state_nxt = DONE;
                end else begin
                    idx_nxt = clr_idx + IDX_W'(1);
                end
            end
            DONE: begin
                busy_nxt  = 1'b0;
                ready_nxt = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign clr_we = (state == CLEAR);

endmodule

// File: rtl/reg_file_32x32.sv
// 32 x 32-bit register file feeding the bitwise datapath units.
// Registered dual read with write-to-read bypass, a valid/ready writeback
// port, and a sequenced clear that zeroes the array without a global reset.
//
// Ports:
//   clk, rst            single clock, synchronous active-high reset
//   rd_en               capture rs1/rs2 into reg_s1/reg_s2 (ignored while busy)
//   rs1_addr, rs2_addr  read addresses
//   reg_s1, reg_s2      registered source operands
//   wb_valid, wb_ready  writeback handshake, transfer when both high
//   wb_addr, reg_d      writeback address and data
//   clr_req             pulse to start a full-array clear
//   busy                clear in progress
module reg_file_32x32 #(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 32,
    parameter int ZERO_REG = 1,
    parameter int ADDR_W   = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rs1_addr,
    input  logic [ADDR_W-1:0] rs2_addr,
    output logic [DATA_W-1:0] reg_s1,
    output logic [DATA_W-1:0] reg_s2,
    input  logic              wb_valid,
    output logic              wb_ready,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] reg_d,
    input  logic              clr_req,
    output logic              busy
);

    logic [DATA_W-1:0] mem [DEPTH];

    logic              clr_we;
    logic [ADDR_W-1:0] clr_idx;
    logic              wb_fire;
    logic              wr_en;
    logic [DATA_W-1:0] s1_nxt;
    logic [DATA_W-1:0] s2_nxt;

    reg_file_clear_ctrl #(
        .N_ENTRIES (DEPTH),
        .IDX_W     (ADDR_W)
    ) u_clear_ctrl (
        .clk      (clk),
        .rst      (rst),
        .clr_req  (clr_req),
        .clr_we   (clr_we),
        .clr_idx  (clr_idx),
        .busy     (busy),
        .wb_ready (wb_ready)
    );

    // A transfer to the hardwired zero register still completes the
    // handshake; only the array write is suppressed.
    assign wb_fire = wb_valid && wb_ready;
    assign wr_en   = wb_fire && !((ZERO_REG != 0) && (wb_addr == '0));

    always_comb begin
        s1_nxt = mem[rs1_addr];
        s2_nxt = mem[rs2_addr];
        if (wr_en && (wb_addr == rs1_addr)) s1_nxt = reg_d;
        if (wr_en && (wb_addr == rs2_addr)) s2_nxt = reg_d;
        if ((ZERO_REG != 0) && (rs1_addr == '0)) s1_nxt = '0;
        if ((ZERO_REG != 0) && (rs2_addr == '0)) s2_nxt = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            reg_s1 <= '0;
            reg_s2 <= '0;
        end else begin
            // wb_ready is low throughout CLEAR, so the two writers never collide.
            if (clr_we) begin
                mem[clr_idx] <= '0;
            end else if (wr_en) begin
                mem[wb_addr] <= reg_d;
            end
            if (rd_en && !busy) begin
                reg_s1 <= s1_nxt;
                reg_s2 <= s2_nxt;
            end
        end
    end

endmodule

// File: tb/tb_reg_file_32x32.sv
module tb_reg_file_32x32;
    import reg_file_32x32_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd_en;
    logic [4:0]  rs1_addr, rs2_addr, wb_addr;
    logic [31:0] reg_s1, reg_s2, reg_d;
    logic        wb_valid, wb_ready, clr_req, busy;

    int checks = 0;
    int passes = 0;

    // Reference: array contents plus the operand values a read should show.
    logic [31:0] model [32];
    logic [31:0] exp_s1, exp_s2;

    always #5 clk = ~clk;

    reg_file_32x32 dut (
        .clk      (clk),
        .rst      (rst),
        .rd_en    (rd_en),
        .rs1_addr (rs1_addr),
        .rs2_addr (rs2_addr),
        .reg_s1   (reg_s1),
        .reg_s2   (reg_s2),
        .wb_valid (wb_valid),
        .wb_ready (wb_ready),
        .wb_addr  (wb_addr),
        .reg_d    (reg_d),
        .clr_req  (clr_req),
        .busy     (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rd_en    = 1'b0;
        rs1_addr = '0;
        rs2_addr = '0;
        wb_valid = 1'b0;
        wb_addr  = '0;
        reg_d    = '0;
        clr_req  = 1'b0;
    endtask

    task automatic model_zero();
        for (int i = 0; i < 32; i++) model[i] = '0;
    endtask

    // A read observes the array as it stands after the same-edge write;
    // register 0 is never written, so it always reads zero.
    task automatic model_step(input bit rd, input logic [4:0] a1, input logic [4:0] a2,
                              input bit fire, input logic [4:0] wa, input logic [31:0] d);
        if (fire && wa != 5'd0) model[wa] = d;
        if (rd) begin
            exp_s1 = model[a1];
            exp_s2 = model[a2];
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        tick();
        tick();
        model_zero();
        exp_s1 = '0;
        exp_s2 = '0;
        checks++; if (reg_s1 !== 32'h0) $display("FAIL reset_s1 got %h want %h", reg_s1, 32'h0); else passes++;
        checks++; if (reg_s2 !== 32'h0) $display("FAIL reset_s2 got %h want %h", reg_s2, 32'h0); else passes++;
        checks++; if (wb_ready !== 1'b0) $display("FAIL reset_ready got %b want 0", wb_ready); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passes++;
        rst = 1'b0;
        tick();
        checks++; if (wb_ready !== 1'b1) $display("FAIL release_ready got %b want 1", wb_ready); else passes++;
        rd_en = 1'b1; rs1_addr = 5'd5; rs2_addr = 5'd31;
        model_step(1, 5'd5, 5'd31, 0, 5'd0, 32'h0);
        tick();
        rd_en = 1'b0;
        checks++; if (reg_s1 !== exp_s1) $display("FAIL post_reset_rd_s1 got %h want %h", reg_s1, exp_s1); else passes++;
        checks++; if (reg_s2 !== exp_s2) $display("FAIL post_reset_rd_s2 got %h want %h", reg_s2, exp_s2); else passes++;
    endtask

    task automatic test_write_read();
        wb_valid = 1'b1; wb_addr = 5'd7; reg_d = 32'hDEADBEEF;
        model_step(0, 5'd0, 5'd0, 1, 5'd7, 32'hDEADBEEF);
        tick();
        wb_valid = 1'b0;
        rd_en = 1'b1; rs1_addr = 5'd7; rs2_addr = 5'd0;
        model_step(1, 5'd7, 5'd0, 0, 5'd0, 32'h0);
        tick();
        rd_en = 1'b0;
        checks++; if (reg_s1 !== 32'hDEADBEEF) $display("FAIL wr_rd_s1 got %h want %h", reg_s1, 32'hDEADBEEF); else passes++;
        checks++; if (reg_s2 !== 32'h0) $display("FAIL wr_rd_s2 got %h want %h", reg_s2, 32'h0); else passes++;
    endtask

    task automatic test_bypass();
        wb_valid = 1'b1; wb_addr = 5'd9; reg_d = 32'h0F0F0F0F;
        rd_en = 1'b1; rs1_addr = 5'd9; rs2_addr = 5'd9;
        model_step(1, 5'd9, 5'd9, 1, 5'd9, 32'h0F0F0F0F);
        tick();
        checks++; if (reg_s1 !== 32'h0F0F0F0F) $display("FAIL bypass_s1 got %h want %h", reg_s1, 32'h0F0F0F0F); else passes++;
        checks++; if (reg_s2 !== 32'h0F0F0F0F) $display("FAIL bypass_s2 got %h want %h", reg_s2, 32'h0F0F0F0F); else passes++;
        wb_addr = 5'd0; reg_d = 32'hFFFFFFFF;
        rs1_addr = 5'd0; rs2_addr = 5'd9;
        model_step(1, 5'd0, 5'd9, 1, 5'd0, 32'hFFFFFFFF);
        tick();
        wb_valid = 1'b0; rd_en = 1'b0;
        checks++; if (reg_s1 !== 32'h0) $display("FAIL bypass_zero_s1 got %h want %h", reg_s1, 32'h0); else passes++;
        checks++; if (reg_s2 !== exp_s2) $display("FAIL bypass_zero_s2 got %h want %h", reg_s2, exp_s2); else passes++;
    endtask

    task automatic test_clear();
        int n;
        bit ready_bad;
        logic [31:0] hold_s1, hold_s2;
        for (int a = 1; a < 32; a++) begin
            wb_valid = 1'b1; wb_addr = 5'(a); reg_d = 32'(a);
            model_step(0, 5'd0, 5'd0, 1, 5'(a), 32'(a));
            tick();
        end
        // Write in the same cycle as the clear request; the clear wipes it later.
        wb_addr = 5'd5; reg_d = 32'hAAAA5555; clr_req = 1'b1;
        tick();
        wb_valid = 1'b0; clr_req = 1'b0;
        hold_s1 = exp_s1;
        hold_s2 = exp_s2;
        n = 0;
        ready_bad = 1'b0;
        while (busy === 1'b1 && n < 100) begin
            if (wb_ready !== 1'b0) ready_bad = 1'b1;
            clr_req = (n == 10);
            rd_en = 1'b1; rs1_addr = 5'd1; rs2_addr = 5'd31;
            tick();
            n++;
        end
        rd_en = 1'b0; clr_req = 1'b0;
        model_zero();
        checks++; if (n != 33) $display("FAIL clear_busy_cycles got %0d want %0d", n, 33); else passes++;
        checks++; if (ready_bad) $display("FAIL clear_ready_low got 1 want 0"); else passes++;
        checks++; if (reg_s1 !== hold_s1) $display("FAIL clear_hold_s1 got %h want %h", reg_s1, hold_s1); else passes++;
        checks++; if (reg_s2 !== hold_s2) $display("FAIL clear_hold_s2 got %h want %h", reg_s2, hold_s2); else passes++;
        checks++; if (wb_ready !== 1'b1) $display("FAIL clear_end_ready got %b want 1", wb_ready); else passes++;
        rd_en = 1'b1; rs1_addr = 5'd1; rs2_addr = 5'd17;
        model_step(1, 5'd1, 5'd17, 0, 5'd0, 32'h0);
        tick();
        checks++; if (reg_s1 !== exp_s1) $display("FAIL clear_rd1 got %h want %h", reg_s1, exp_s1); else passes++;
        checks++; if (reg_s2 !== exp_s2) $display("FAIL clear_rd17 got %h want %h", reg_s2, exp_s2); else passes++;
        rs1_addr = 5'd31; rs2_addr = 5'd5;
        model_step(1, 5'd31, 5'd5, 0, 5'd0, 32'h0);
        tick();
        rd_en = 1'b0;
        checks++; if (reg_s1 !== exp_s1) $display("FAIL clear_rd31 got %h want %h", reg_s1, exp_s1); else passes++;
        checks++; if (reg_s2 !== exp_s2) $display("FAIL clear_rd5 got %h want %h", reg_s2, exp_s2); else passes++;
    endtask

    task automatic test_stall();
        int n;
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        wb_valid = 1'b1; wb_addr = 5'd3; reg_d = 32'h12345678;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            tick();
            n++;
        end
        checks++; if (wb_ready !== 1'b1 || busy !== 1'b0) $display("FAIL stall_release got ready=%b busy=%b want ready=1 busy=0", wb_ready, busy); else passes++;
        model_zero();
        // First ready cycle: the held request transfers and bypasses into a same-edge read.
        rd_en = 1'b1; rs1_addr = 5'd3; rs2_addr = 5'd4;
        model_step(1, 5'd3, 5'd4, 1, 5'd3, 32'h12345678);
        tick();
        wb_valid = 1'b0;
        checks++; if (reg_s1 !== exp_s1) $display("FAIL stall_first_ready got %h want %h", reg_s1, exp_s1); else passes++;
        rs1_addr = 5'd0; rs2_addr = 5'd3;
        model_step(1, 5'd0, 5'd3, 0, 5'd0, 32'h0);
        tick();
        rd_en = 1'b0;
        checks++; if (reg_s2 !== exp_s2) $display("FAIL stall_readback got %h want %h", reg_s2, exp_s2); else passes++;
        checks++; if (reg_s1 !== exp_s1) $display("FAIL stall_readback_r0 got %h want %h", reg_s1, exp_s1); else passes++;
    endtask

    task automatic test_reset_mid_clear();
        wb_valid = 1'b1; wb_addr = 5'd20; reg_d = 32'hCAFEF00D;
        model_step(0, 5'd0, 5'd0, 1, 5'd20, 32'hCAFEF00D);
        tick();
        wb_addr = 5'd31; reg_d = 32'h5A5A5A5A;
        model_step(0, 5'd0, 5'd0, 1, 5'd31, 32'h5A5A5A5A);
        tick();
        wb_valid = 1'b0;
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        rst = 1'b1;
        tick();
        model_zero();
        exp_s1 = '0;
        exp_s2 = '0;
        checks++; if (busy !== 1'b0) $display("FAIL midclr_busy got %b want 0", busy); else passes++;
        checks++; if (reg_s1 !== 32'h0) $display("FAIL midclr_s1 got %h want %h", reg_s1, 32'h0); else passes++;
        rst = 1'b0;
        tick();
        checks++; if (wb_ready !== 1'b1) $display("FAIL midclr_ready got %b want 1", wb_ready); else passes++;
        tick();
        checks++; if (busy !== 1'b0) $display("FAIL midclr_idle got %b want 0", busy); else passes++;
        rd_en = 1'b1; rs1_addr = 5'd20; rs2_addr = 5'd31;
        model_step(1, 5'd20, 5'd31, 0, 5'd0, 32'h0);
        tick();
        rd_en = 1'b0;
        checks++; if (reg_s1 !== exp_s1) $display("FAIL midclr_rd20 got %h want %h", reg_s1, exp_s1); else passes++;
        checks++; if (reg_s2 !== exp_s2) $display("FAIL midclr_rd31 got %h want %h", reg_s2, exp_s2); else passes++;
    endtask

    task automatic test_random();
        bit          rd, wv;
        logic [4:0]  a1, a2, wa;
        logic [31:0] d;
        for (int i = 0; i < 300; i++) begin
            rd = 1'($urandom_range(0, 1));
            wv = 1'($urandom_range(0, 1));
            a1 = 5'($urandom_range(0, 31));
            a2 = ($urandom_range(0, 3) == 0) ? a1 : 5'($urandom_range(0, 31));
            wa = ($urandom_range(0, 2) == 0) ? a1 : 5'($urandom_range(0, 31));
            d  = $urandom;
            rd_en = rd; rs1_addr = a1; rs2_addr = a2;
            wb_valid = wv; wb_addr = wa; reg_d = d;
            model_step(rd, a1, a2, wv, wa, d);
            tick();
            checks++; if (reg_s1 !== exp_s1) $display("FAIL rand_s1 i=%0d got %h want %h", i, reg_s1, exp_s1); else passes++;
            checks++; if (reg_s2 !== exp_s2) $display("FAIL rand_s2 i=%0d got %h want %h", i, reg_s2, exp_s2); else passes++;
            checks++; if (wb_ready !== 1'b1 || busy !== 1'b0) $display("FAIL rand_ctrl i=%0d got ready=%b busy=%b want ready=1 busy=0", i, wb_ready, busy); else passes++;
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        test_reset();
        test_write_read();
        test_bypass();
        test_random();
        test_clear();
        test_stall();
        test_random();
        test_reset_mid_clear();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/reg_file_32x32.md
Name: reg_file_32x32

Overview:
- 32-entry x 32-bit register file that is the source and sink of the bitwise datapath units.
- Drives the source operands reg_s1/reg_s2 into the units, and accepts their reg_d result through a valid/ready writeback handshake.
- Provides a registered read with write-to-read bypass, and a sequenced clear engine that zeroes the array without a global reset.

Parameters:
- DATA_W, 32, operand/result width.
- DEPTH, 32, number of registers; the address width is log2(DEPTH).
- ZERO_REG, 1, when 1 register 0 always reads 0 and writes to it are dropped.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous active-high reset.
- rd_en  in  1  capture a read this cycle.
- rs1_addr  in  5  source-1 address.
- rs2_addr  in  5  source-2 address.
- reg_s1  out  32  registered source-1 operand.
- reg_s2  out  32  registered source-2 operand.
- wb_valid  in  1  writeback request.
- wb_ready  out  1  writeback accepted when high with wb_valid.
- wb_addr  in  5  destination address.
- reg_d  in  32  writeback data from a datapath unit.
- clr_req  in  1  one-cycle pulse that starts a full-array clear.
- busy  out  1  clear in progress.

Behaviour:
- Reset: one clock is the only clock; reset is synchronous and active-high (clk, rst). While rst is high at a clk edge:
  - all array entries become 0;
  - reg_s1 = reg_s2 = 0;
  - wb_ready = 0, busy = 0;
  - FSM = IDLE.
  - wb_ready rises on the first edge after rst deasserts.
- Reset mid-clear: aborts the clear and returns the FSM to IDLE; the array is zero anyway.
- Write:
  - A transfer occurs at an edge where wb_valid && wb_ready.
  - The array entry at wb_addr takes reg_d at that edge.
  - If ZERO_REG=1 and wb_addr == 0, the transfer completes and the data is discarded.
- Read:
  - Latency is one cycle. At an edge with rd_en=1, reg_s1 <= value(rs1_addr) and reg_s2 <= value(rs2_addr).
  - With rd_en=0, both outputs hold their value.
- Bypass: if a write transfer happens at the same edge and wb_addr matches a read address, that output takes reg_d (the new data), not the old entry. Exception: address 0 when ZERO_REG=1, which yields 0.
- Same-address reads: rs1_addr == rs2_addr is legal; both outputs show the same value.
- Clear FSM, states IDLE, CLEAR, DONE:
  - IDLE -> CLEAR on clr_req=1: index counter <= 0, busy <= 1, wb_ready <= 0.
  - CLEAR: each edge writes entry[idx] <= 0 and increments idx. Transition to DONE when entry DEPTH-1 is written; the index does not wrap.
  - DONE: busy <= 0 and wb_ready <= 1, then -> IDLE.
  - Total busy time is DEPTH+1 cycles from the first high of busy to its deassertion.
- Simultaneous clr_req and write transfer in IDLE: the write is performed at that edge, then the clear begins and later zeroes that entry.
- clr_req while busy: ignored, with no restart and no queuing.
- Reads while busy:
  - rd_en is ignored; reg_s1/reg_s2 hold.
  - The bench must not expect updated operands until busy=0.
- wb_ready is low throughout CLEAR and DONE. A wb_valid held during that window is stalled, not dropped; the transfer completes once wb_ready=1.
- Output purity: no combinational path from any input to any output; reg_s1, reg_s2, wb_ready and busy are all flops.

Decomposition:
- Shared package:
  - DATA_W and the address width constant;
  - the clear FSM state enum {IDLE, CLEAR, DONE};
  - a reg_addr_t typedef reused by the datapath units' address buses.
- Sub-module reg_file_clear_ctrl holds the FSM and index counter. It outputs the clear write-enable and index, busy, and a wb_ready gate.
- The top level holds the array, the write mux between writeback and clear, the bypass compare, and the output flops.

Test Plan:
- Reset, then release:
  - With rst=1 for 2 cycles: reg_s1 = reg_s2 = 0, wb_ready = 0, busy = 0.
  - On the first edge after release: wb_ready = 1.
  - Then rd_en with rs1=5, rs2=31: both operands read 0x00000000 one cycle later.
- Write then read: write addr 7 = 0xDEADBEEF, then the next cycle rd_en with rs1=7, rs2=0 -> reg_s1 = 0xDEADBEEF, reg_s2 = 0.
- Bypass at the same edge:
  - Write addr 9 = 0x0F0F0F0F with rd_en, rs1=9, rs2=9 -> both = 0x0F0F0F0F one cycle later.
  - Write addr 0 = 0xFFFFFFFF with rs1=0 -> reg_s1 = 0.
- Clear sequence:
  - Fill regs 1..31 with their index, then pulse clr_req.
  - busy is high for exactly 33 cycles (DEPTH+1), and wb_ready is low over the same window.
  - clr_req pulsed mid-clear has no effect.
  - Afterwards, reads of addr 1, 17 and 31 all return 0.
- Stalled writeback: hold wb_valid with addr 3 = 0x12345678 during busy. The transfer fires on the first cycle wb_ready=1, and a subsequent read of addr 3 = 0x12345678.
- Reset mid-clear: assert rst at clear index 10 -> busy = 0 after the edge, all entries are 0, and the FSM idles with wb_ready = 1 after release.
